// File: rtl/i2c_target.sv
//==============================================================================
// i2c_target : I2C target giving a byte-wide register port (sub-address + auto-
// incrementing data bytes). Define I2C_READ_EN to add read transactions.
// Revision   : 1.0
//==============================================================================
`default_nettype none

module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h70
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
  } state_t;

`ifdef I2C_READ_EN
  localparam logic READ_EN = 1'b1;
`else
  localparam logic READ_EN = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [2:0] sda_s_q, scl_s_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_en_q, wr_en_d;
  logic       busy_q, busy_d;

  // [1] is the synchronized level, [2] its previous value for edge detection
  logic       w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;
  assign w_sda      = sda_s_q[1];
  assign w_scl_rise =  scl_s_q[1] & ~scl_s_q[2];
  assign w_scl_fall = ~scl_s_q[1] &  scl_s_q[2];
  assign w_start    = scl_s_q[1] & scl_s_q[2] &  sda_s_q[2] & ~sda_s_q[1];
  assign w_stop     = scl_s_q[1] & scl_s_q[2] & ~sda_s_q[2] &  sda_s_q[1];
  assign w_byte     = {shift_q[6:0], w_sda};

`ifdef I2C_READ_EN
  logic rw_q, rw_d;
  logic ackd_q, ackd_d;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^{reg_rdata, shift_q[7]};
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
`ifdef I2C_READ_EN
    rw_d      = rw_q;
    ackd_d    = ackd_q;
`endif
    if (w_start) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
`ifdef I2C_READ_EN
      ackd_d    = 1'b0;
`endif
    end else if (w_stop) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (w_scl_rise) begin
          shift_d   = w_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (w_byte[7:1] == DEV_ADDR && (!w_byte[0] || READ_EN))
              state_d = S_ADDR_ACK;
            else
              state_d = S_WAIT;
`ifdef I2C_READ_EN
            rw_d = w_byte[0];
`endif
          end
        end
        S_SUB: if (w_scl_rise) begin
          shift_d   = w_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d  = w_byte;
            state_d = S_SUB_ACK;
          end
        end
        S_WDATA: if (w_scl_rise) begin
          shift_d   = w_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wdata_d = w_byte;
            wr_en_d = 1'b1;
            state_d = S_WDATA_ACK;
          end
        end
        // First SCL fall drives the ACK, the second one ends the slot
        S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: if (w_scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            if (state_q == S_WDATA_ACK) begin
              addr_d  = addr_q + 8'd1;
              state_d = S_WDATA;
            end else if (state_q == S_SUB_ACK) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_SUB;
`ifdef I2C_READ_EN
              if (rw_q) begin
                shift_d  = reg_rdata;
                sda_oe_d = ~reg_rdata[7];
                state_d  = S_RDATA;
              end
`endif
            end
          end
        end
`ifdef I2C_READ_EN
        S_RDATA: begin
          if (w_scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = S_RDATA_ACK;
          end else if (w_scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        // Release after bit 8, sample controller ACK, then load the next byte
        S_RDATA_ACK: begin
          if (w_scl_fall) begin
            if (ackd_q) begin
              shift_d  = reg_rdata;
              sda_oe_d = ~reg_rdata[7];
              ackd_d   = 1'b0;
              state_d  = S_RDATA;
            end else begin
              sda_oe_d = 1'b0;
            end
          end else if (w_scl_rise) begin
            addr_d = addr_q + 8'd1;
            if (w_sda) state_d = S_WAIT;
            else       ackd_d  = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sda_s_q   <= 3'b111;
      scl_s_q   <= 3'b111;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef I2C_READ_EN
      rw_q      <= 1'b0;
      ackd_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sda_s_q   <= {sda_s_q[1:0], sda_in};
      scl_s_q   <= {scl_s_q[1:0], scl_in};
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sda_oe_q  <= sda_oe_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
`ifdef I2C_READ_EN
      rw_q      <= rw_d;
      ackd_q    <= ackd_d;
`endif
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_en_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire
